// File: rtl/mem_iface.sv
// Multicycle-CPU memory interface: captures one access request, runs it to memory,
// and loads the instruction/data registers on completion or flags a sticky timeout.
module mem_iface #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        iord,
    input  logic        memwrite,
    input  logic        irwrite,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] wd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] mdr,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        irw_q, irw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] mdr_q, mdr_d;
    logic        err_q, err_d;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            irw_q   <= 1'b0;
            cnt_q   <= '0;
            instr_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            irw_q   <= irw_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        irw_d     = irw_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        mdr_d     = mdr_q;
        err_d     = err_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        stall     = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so stall drops asynchronously even while req is held.
                stall = req && !reset;
                if (req) begin
                    addr_d  = iord ? aluout : pc;
                    wdata_d = wd;
                    we_d    = memwrite;
                    irw_d   = irwrite;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall     = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_rd    = !we_q;
                mem_wr    = we_q;
                // Completion takes priority over a timeout landing in the same cycle.
                if (mem_ready) begin
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                        if (irw_q) instr_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign instr = instr_q;
    assign op    = instr_q[31:26];
    assign mdr   = mdr_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_iface.sv
// Directed bench for mem_iface: fetch, store, timeout, late completion and mid-access reset.
module tb_mem_iface;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, iord, memwrite, irwrite;
    logic [31:0] pc, aluout, wd;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] instr, mdr;
    logic [5:0]  op;
    logic        stall, err;

    int total = 0;
    int bad   = 0;

    mem_iface #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req(req), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .pc(pc), .aluout(aluout), .wd(wd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr), .op(op),
        .mdr(mdr), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".rd"},    32'(mem_rd),   32'd0);
        check({tag, ".wr"},    32'(mem_wr),   32'd0);
        check({tag, ".addr"},  mem_addr,      32'd0);
        check({tag, ".wdata"}, mem_wdata,     32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
        pc = 32'h0; aluout = 32'h0; wd = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        #1;
        check_idle_outs("rst");
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.op",    32'(op), 32'd0);
        check("rst.mdr",   mdr, 32'd0);
        check("rst.err",   32'(err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Fetch with ready in the first ACCESS cycle.
        req = 1'b1; iord = 1'b0; irwrite = 1'b1; pc = 32'h0040_0000; aluout = 32'h1234_5678;
        #1;
        check("f.c0.stall", 32'(stall), 32'd1);
        check("f.c0.rd",    32'(mem_rd), 32'd0);
        tick();
        pc = 32'hFFFF_0000; iord = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h8C08_0004;
        #1;
        check("f.c1.stall", 32'(stall), 32'd1);
        check("f.c1.rd",    32'(mem_rd), 32'd1);
        check("f.c1.wr",    32'(mem_wr), 32'd0);
        check("f.c1.addr",  mem_addr, 32'h0040_0000);
        tick();
        mem_ready = 1'b0;
        check("f.c2.stall", 32'(stall), 32'd0);
        check_idle_outs("f.c2");
        check("f.instr", instr, 32'h8C08_0004);
        check("f.op",    32'(op), 32'h23);
        check("f.mdr",   mdr, 32'h8C08_0004);
        tick();
        req = 1'b0;
        #1;
        check("f.idle.stall", 32'(stall), 32'd0);

        // Ready pulse while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        tick();
        mem_ready = 1'b0;
        check("idle.rdy.mdr",   mdr, 32'h8C08_0004);
        check("idle.rdy.instr", instr, 32'h8C08_0004);
        check("idle.rdy.rd",    32'(mem_rd), 32'd0);

        // Store, ready on the third ACCESS cycle; inputs scrambled after capture.
        req = 1'b1; iord = 1'b1; memwrite = 1'b1; irwrite = 1'b1;
        aluout = 32'h1001_0004; wd = 32'hDEAD_BEEF; pc = 32'h0;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("s.c0.stall", 32'(stall), 32'd1);
        tick();
        aluout = 32'h0; wd = 32'h0; memwrite = 1'b0; iord = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            check($sformatf("s.a%0d.stall", i), 32'(stall), 32'd1);
            check($sformatf("s.a%0d.wr", i),    32'(mem_wr), 32'd1);
            check($sformatf("s.a%0d.rd", i),    32'(mem_rd), 32'd0);
            check($sformatf("s.a%0d.addr", i),  mem_addr, 32'h1001_0004);
            check($sformatf("s.a%0d.wdata", i), mem_wdata, 32'hDEAD_BEEF);
            tick();
        end
        mem_ready = 1'b0;
        check("s.done.stall", 32'(stall), 32'd0);
        check("s.instr", instr, 32'h8C08_0004);
        check("s.mdr",   mdr, 32'h8C08_0004);
        check("s.err",   32'(err), 32'd0);
        req = 1'b0;
        tick();

        // Timeout: read never answered, abort after exactly 15 ACCESS cycles.
        req = 1'b1; iord = 1'b0; irwrite = 1'b0; memwrite = 1'b0; pc = 32'h0040_0010;
        tick();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("t.a%0d.stall", i), 32'(stall), 32'd1);
            check($sformatf("t.a%0d.rd", i),    32'(mem_rd), 32'd1);
            check($sformatf("t.a%0d.err", i),   32'(err), 32'd0);
            tick();
        end
        check("t.done.stall", 32'(stall), 32'd0);
        check("t.done.rd",    32'(mem_rd), 32'd0);
        check("t.err",        32'(err), 32'd1);
        check("t.mdr",        mdr, 32'h8C08_0004);
        req = 1'b0;
        tick();

        // Normal read after timeout: completes, err stays set.
        req = 1'b1; irwrite = 1'b1; pc = 32'h0040_0020;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h2002_0005;
        tick();
        mem_ready = 1'b0;
        check("t2.instr", instr, 32'h2002_0005);
        check("t2.op",    32'(op), 32'h08);
        check("t2.mdr",   mdr, 32'h2002_0005);
        check("t2.err",   32'(err), 32'd1);
        req = 1'b0;
        tick();

        // Asynchronous reset between edges clears everything including err.
        #2 reset = 1'b1;
        #1;
        check("r1.err",   32'(err), 32'd0);
        check("r1.instr", instr, 32'd0);
        check("r1.mdr",   mdr, 32'd0);
        #1 reset = 1'b0;
        tick();

        // Ready arriving on the last counter value: completion wins, no error.
        req = 1'b1; irwrite = 1'b0; pc = 32'h0040_0030;
        tick();
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("l.a14.stall", 32'(stall), 32'd1);
        tick();
        mem_ready = 1'b0;
        check("l.stall", 32'(stall), 32'd0);
        check("l.mdr",   mdr, 32'hCAFE_F00D);
        check("l.instr", instr, 32'd0);
        check("l.err",   32'(err), 32'd0);
        req = 1'b0;
        tick();

        // Reset mid-ACCESS aborts the read; a later idle ready pulse changes nothing.
        req = 1'b1; irwrite = 1'b1; pc = 32'h0040_0040;
        tick();
        check("m.rd.before", 32'(mem_rd), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle_outs("m.rst");
        check("m.rst.stall", 32'(stall), 32'd0);
        check("m.rst.mdr",   mdr, 32'd0);
        check("m.rst.instr", instr, 32'd0);
        check("m.rst.op",    32'(op), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        check("m.hold.rd",    32'(mem_rd), 32'd0);
        check("m.hold.mdr",   mdr, 32'd0);
        reset = 1'b0; req = 1'b0;
        tick();
        tick();
        mem_ready = 1'b0;
        check("m.idle.mdr",   mdr, 32'd0);
        check("m.idle.instr", instr, 32'd0);

        // Fresh access after release works normally.
        req = 1'b1; iord = 1'b1; aluout = 32'h1001_0008;
        tick();
        check("m.new.addr", mem_addr, 32'h1001_0008);
        mem_ready = 1'b1; mem_rdata = 32'h0123_4567;
        tick();
        mem_ready = 1'b0; req = 1'b0;
        check("m.new.mdr",   mdr, 32'h0123_4567);
        check("m.new.instr", instr, 32'h0123_4567);
        check("m.new.op",    32'(op), 32'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
